// File: rtl/s2p_pkg.sv
// Shared state encoding and default configuration for the comma-aligning
// serial-to-parallel converter.
package s2p_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int         DEF_WIDTH      = 8;
    localparam logic [7:0] DEF_COMMA      = 8'hBC;
    localparam int         DEF_LOCK_COUNT = 4;
    localparam int         DEF_MAX_GAP    = 64;

endpackage

// File: rtl/s2p_lane.sv
// One serial lane: sliding comma hunt, word-boundary alignment check, locked delivery.
// Optional loss-of-sync supervision is compiled in with `define S2P_LOS_EN.
module s2p_lane
    import s2p_pkg::*;
#(
    parameter int               WIDTH      = DEF_WIDTH,
    parameter logic [WIDTH-1:0] COMMA      = WIDTH'(DEF_COMMA),
    parameter int               LOCK_COUNT = DEF_LOCK_COUNT,
    parameter int               MAX_GAP    = DEF_MAX_GAP
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_serial,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_active,
    output logic             o_idle
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = (LOCK_COUNT > 0) ? $clog2(LOCK_COUNT + 1) : 1;

    if (LOCK_COUNT < 1 || MAX_GAP < 1 || WIDTH < 2) begin : g_bad_cfg
        $error("s2p_lane: WIDTH >= 2, LOCK_COUNT >= 1 and MAX_GAP >= 1 required");
    end

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [BW-1:0]    r_bitcnt;
    logic [CW-1:0]    r_commacnt;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_active;
    logic             r_idle;
`ifdef S2P_LOS_EN
    localparam int GW = $clog2(MAX_GAP + 1);
    logic [GW-1:0]    r_gapcnt;
`endif

    logic [WIDTH-1:0] w_nxt;
    logic             w_boundary;
    logic             w_comma;

    assign w_nxt      = {r_shreg[WIDTH-2:0], i_serial};
    assign w_boundary = (r_bitcnt == BW'(WIDTH - 1));
    assign w_comma    = (w_nxt == COMMA);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= HUNT;
            r_shreg    <= '0;
            r_bitcnt   <= '0;
            r_commacnt <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_active   <= 1'b0;
            r_idle     <= 1'b0;
`ifdef S2P_LOS_EN
            r_gapcnt   <= '0;
`endif
        end else begin
            r_shreg  <= w_nxt;
            r_bitcnt <= w_boundary ? '0 : r_bitcnt + 1'b1;
            r_valid  <= 1'b0;
            case (r_state)
                HUNT: begin
                    // Sliding search: a match anywhere fixes the word boundary
                    if (w_comma) begin
                        r_bitcnt   <= '0;
                        r_commacnt <= CW'(1);
                        if (LOCK_COUNT == 1) begin
                            r_state  <= LOCKED;
                            r_active <= 1'b1;
                            r_idle   <= 1'b1;
                        end else begin
                            r_state <= ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    if (w_boundary) begin
                        if (w_comma) begin
                            if (r_commacnt != CW'(LOCK_COUNT))
                                r_commacnt <= r_commacnt + 1'b1;
                            if (r_commacnt >= CW'(LOCK_COUNT - 1)) begin
                                r_state  <= LOCKED;
                                r_active <= 1'b1;
                                r_idle   <= 1'b1;
                            end
                        end else begin
                            r_state    <= HUNT;
                            r_commacnt <= '0;
                        end
                    end
                end
                LOCKED: begin
                    if (w_boundary) begin
                        if (w_comma) begin
                            r_idle <= 1'b1;
`ifdef S2P_LOS_EN
                            r_gapcnt <= '0;
`endif
                        end else begin
                            r_data  <= w_nxt;
                            r_valid <= 1'b1;
                            r_idle  <= 1'b0;
`ifdef S2P_LOS_EN
                            // The word that overruns the gap is still delivered
                            if (r_gapcnt == GW'(MAX_GAP)) begin
                                r_state    <= HUNT;
                                r_active   <= 1'b0;
                                r_commacnt <= '0;
                                r_gapcnt   <= '0;
                            end else begin
                                r_gapcnt <= r_gapcnt + 1'b1;
                            end
`endif
                        end
                    end
                end
                default: r_state <= HUNT;
            endcase
        end
    end

    assign o_data   = r_data;
    assign o_valid  = r_valid;
    assign o_active = r_active;
    assign o_idle   = r_idle;

endmodule

// File: rtl/s2p_comma_align.sv
// Multi-lane serial-to-parallel converter with per-lane comma alignment and lock.
// Lanes are independent; `define S2P_LOS_EN enables loss-of-sync in every lane.
module s2p_comma_align
    import s2p_pkg::*;
#(
    parameter int               LANES      = 1,
    parameter int               WIDTH      = DEF_WIDTH,
    parameter logic [WIDTH-1:0] COMMA      = WIDTH'(DEF_COMMA),
    parameter int               LOCK_COUNT = DEF_LOCK_COUNT,
    parameter int               MAX_GAP    = DEF_MAX_GAP
) (
    input  logic                   clk_32f,
    input  logic                   reset,
    input  logic [LANES-1:0]       serial_in,
    output logic [LANES*WIDTH-1:0] data_out,
    output logic [LANES-1:0]       valid,
    output logic [LANES-1:0]       active,
    output logic [LANES-1:0]       idle_out
);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        s2p_lane #(
            .WIDTH      (WIDTH),
            .COMMA      (COMMA),
            .LOCK_COUNT (LOCK_COUNT),
            .MAX_GAP    (MAX_GAP)
        ) u_lane (
            .i_clk    (clk_32f),
            .i_rst    (reset),
            .i_serial (serial_in[g]),
            .o_data   (data_out[g*WIDTH +: WIDTH]),
            .o_valid  (valid[g]),
            .o_active (active[g]),
            .o_idle   (idle_out[g])
        );
    end

endmodule

// File: tb/tb_s2p_comma_align.sv
// Scoreboard bench for s2p_comma_align: three configurations share one clock.
module tb_s2p_comma_align;

    logic clk;
    logic rst;

    logic [0:0]  sin0, sin1;
    logic [1:0]  sin2;
    logic [7:0]  d0, d1;
    logic [19:0] d2;
    logic [0:0]  v0, a0, i0, v1, a1, i1;
    logic [1:0]  v2, a2, i2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [15:0] q2[$];

    s2p_comma_align #(.LANES(1), .WIDTH(8), .COMMA(8'hBC), .LOCK_COUNT(4), .MAX_GAP(4)) u_dut0 (
        .clk_32f(clk), .reset(rst), .serial_in(sin0),
        .data_out(d0), .valid(v0), .active(a0), .idle_out(i0));

    s2p_comma_align #(.LANES(1), .WIDTH(8), .COMMA(8'hBC), .LOCK_COUNT(1), .MAX_GAP(64)) u_dut1 (
        .clk_32f(clk), .reset(rst), .serial_in(sin1),
        .data_out(d1), .valid(v1), .active(a1), .idle_out(i1));

    s2p_comma_align #(.LANES(2), .WIDTH(10), .COMMA(10'h17C), .LOCK_COUNT(4), .MAX_GAP(64)) u_dut2 (
        .clk_32f(clk), .reset(rst), .serial_in(sin2),
        .data_out(d2), .valid(v2), .active(a2), .idle_out(i2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic send(input int dut, input logic [15:0] w, input int nbits);
        for (int b = nbits - 1; b >= 0; b--) begin
            case (dut)
                0:       sin0[0] = w[b];
                1:       sin1[0] = w[b];
                default: sin2[0] = w[b];
            endcase
            @(posedge clk);
            #1;
        end
    endtask

    // Lets the last word's valid reach the monitor before reset wipes it
    task automatic do_reset();
        sin0 = '0; sin1 = '0; sin2 = '0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every valid strobe pops the next expected word for that DUT
    always @(negedge clk) begin
        logic [15:0] e;
        if (v0[0]) begin
            n_checks++;
            if (q0.size() == 0) begin
                n_fail++;
                $display("FAIL dut0_valid: got data %0h, expected no valid", d0);
            end else begin
                e = q0.pop_front();
                if (d0 !== e[7:0]) begin
                    n_fail++;
                    $display("FAIL dut0_data: got %0h, expected %0h", d0, e[7:0]);
                end
            end
        end
        if (v1[0]) begin
            n_checks++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL dut1_valid: got data %0h, expected no valid", d1);
            end else begin
                e = q1.pop_front();
                if (d1 !== e[7:0]) begin
                    n_fail++;
                    $display("FAIL dut1_data: got %0h, expected %0h", d1, e[7:0]);
                end
            end
        end
        if (v2[0]) begin
            n_checks++;
            if (q2.size() == 0) begin
                n_fail++;
                $display("FAIL dut2_lane0_valid: got data %0h, expected no valid", d2[9:0]);
            end else begin
                e = q2.pop_front();
                if (d2[9:0] !== e[9:0]) begin
                    n_fail++;
                    $display("FAIL dut2_lane0_data: got %0h, expected %0h", d2[9:0], e[9:0]);
                end
            end
        end
        if (v2[1]) begin
            n_checks++;
            n_fail++;
            $display("FAIL dut2_lane1_valid: got 1, expected 0");
        end
    end

    initial begin
        rst  = 1'b1;
        sin0 = '0; sin1 = '0; sin2 = '0;

        // Reset held for three edges with toggling inputs
        for (int k = 0; k < 3; k++) begin
            sin0 = 1'(k); sin1 = 1'(k + 1); sin2 = 2'(k);
            @(posedge clk);
            #1;
        end
        check("rst_d0", {24'd0, d0}, 0);
        check("rst_v0a0i0", {29'd0, v0, a0, i0}, 0);
        check("rst_d1v1a1i1", {21'd0, d1, v1, a1, i1}, 0);
        check("rst_d2", {12'd0, d2}, 0);
        check("rst_v2a2i2", {26'd0, v2, a2, i2}, 0);
        sin0 = '0; sin1 = '0; sin2 = '0;
        rst = 1'b0;

        // Lock on four commas, then two data words
        repeat (3) send(0, 16'hBC, 8);
        check("lock_active_after_3", {31'd0, a0}, 0);
        send(0, 16'hBC, 8);
        check("lock_active_after_4", {31'd0, a0}, 1);
        check("lock_idle_after_4", {31'd0, i0}, 1);
        q0.push_back(16'hFF);
        send(0, 16'hFF, 8);
        check("lock_idle_after_ff", {31'd0, i0}, 0);
        q0.push_back(16'hEE);
        send(0, 16'hEE, 8);
        check("lock_data_held", {24'd0, d0}, 32'hEE);

        // Asynchronous reset while locked
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_active", {31'd0, a0}, 0);
        check("async_rst_data", {24'd0, d0}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Misaligned start: three junk bits before the preamble
        send(0, 16'h0006, 3);
        repeat (4) send(0, 16'hBC, 8);
        check("misalign_active", {31'd0, a0}, 1);
        q0.push_back(16'h5A);
        send(0, 16'h5A, 8);
        check("misalign_data", {24'd0, d0}, 32'h5A);
        do_reset();

        // Broken preamble falls back to hunting
        send(0, 16'hBC, 8);
        send(0, 16'hBC, 8);
        send(0, 16'h55, 8);
        check("broken_active_after_55", {31'd0, a0}, 0);
        repeat (3) send(0, 16'hBC, 8);
        check("broken_active_after_3bc", {31'd0, a0}, 0);
        send(0, 16'hBC, 8);
        check("broken_active_after_4bc", {31'd0, a0}, 1);
        q0.push_back(16'hA3);
        send(0, 16'hA3, 8);
        do_reset();

        // LOCK_COUNT of one: a single comma locks
        send(1, 16'hBC, 8);
        check("lc1_active", {31'd0, a1}, 1);
        check("lc1_idle", {31'd0, i1}, 1);
        q1.push_back(16'h3C);
        send(1, 16'h3C, 8);
        check("lc1_idle_after_data", {31'd0, i1}, 0);
        do_reset();

        // Two 10-bit lanes, lane1 tied low
        repeat (4) send(2, 16'h017C, 10);
        check("ml_active", {30'd0, a2}, 32'h1);
        q2.push_back(16'h02A5);
        send(2, 16'h02A5, 10);
        q2.push_back(16'h0155);
        send(2, 16'h0155, 10);
        check("ml_lane1_data", {22'd0, d2[19:10]}, 0);
        check("ml_active_hold", {30'd0, a2}, 32'h1);
        check("ml_idle", {30'd0, i2}, 0);
        do_reset();

`ifdef S2P_LOS_EN
        // Loss of sync after MAX_GAP data words, then relock
        repeat (4) send(0, 16'hBC, 8);
        for (int k = 1; k <= 4; k++) begin
            q0.push_back(16'(k * 16'h11));
            send(0, 16'(k * 16'h11), 8);
        end
        check("los_active_at_gap", {31'd0, a0}, 1);
        q0.push_back(16'h55);
        send(0, 16'h55, 8);
        check("los_active_dropped", {31'd0, a0}, 0);
        check("los_idle_dropped", {31'd0, i0}, 0);
        repeat (3) send(0, 16'hBC, 8);
        check("los_relock_after_3", {31'd0, a0}, 0);
        send(0, 16'hBC, 8);
        check("los_relock_after_4", {31'd0, a0}, 1);
        q0.push_back(16'h66);
        send(0, 16'h66, 8);
        do_reset();
`else
        // Without loss-of-sync, a long comma-free run keeps the lock
        repeat (4) send(0, 16'hBC, 8);
        for (int k = 1; k <= 6; k++) begin
            q0.push_back(16'(k * 16'h11));
            send(0, 16'(k * 16'h11), 8);
        end
        check("nolos_active_held", {31'd0, a0}, 1);
        check("nolos_idle", {31'd0, i0}, 0);
        do_reset();
`endif

        repeat (2) @(negedge clk);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
